memoria_dados: RTL and testbench

MEMORIA_DADOS -- requirements
Module: memoria_dados

---
 rtl/memoria_dados.sv | 181 ++++++++++++++++++
 tb/tb_memoria_dados.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados.sv
// Data memory for the pipeline's memory stage: byte-enabled writes, configurable wait latency, alignment and range errors.
// Build option: define MEM_INIT_EN to preload word i with the value i at time zero.
module memoria_dados #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                erro
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPOSTA = 2'd2
  } state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              ready_reg;
  logic              done_reg;
  logic              erro_reg;
  logic              rsel_reg;
  logic              we_reg;
  logic              err_reg;
  logic [AW-1:0]     idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [NB-1:0]     be_reg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [31-OFF_W:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;

  logic              acc_we;
  logic              acc_err;
  logic [AW-1:0]     acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic [NB-1:0]     acc_be;
  logic              go_resp;

  assign word_idx     = addr[31:OFF_W];
  assign out_of_range = 33'(word_idx) >= 33'(DEPTH);
  assign req_err      = misaligned | out_of_range;
  assign accept       = req & ready_reg;

  generate
    if (OFF_W == 0) begin : g_no_offset
      assign misaligned = 1'b0;
    end else begin : g_offset
      assign misaligned = |addr[OFF_W-1:0];
    end
  endgenerate

  // With no wait state the memory acts on the request in the acceptance cycle,
  // so it must see the live inputs rather than the captured copies.
  generate
    if (WAIT_CYCLES == 0) begin : g_direct
      assign acc_we    = we;
      assign acc_err   = req_err;
      assign acc_idx   = word_idx[AW-1:0];
      assign acc_wdata = wdata;
      assign acc_be    = be;
      assign go_resp   = accept & ~reset;
    end else begin : g_waited
      assign acc_we    = we_reg;
      assign acc_err   = err_reg;
      assign acc_idx   = idx_reg;
      assign acc_wdata = wdata_reg;
      assign acc_be    = be_reg;
      assign go_resp   = (state_reg == ESPERA) && (cnt_reg == 4'd0) && !reset;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= OCIOSO;
      cnt_reg   <= 4'd0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      erro_reg  <= 1'b0;
      rsel_reg  <= 1'b0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      erro_reg <= 1'b0;
      case (state_reg)
        OCIOSO: begin
          if (accept) begin
            we_reg    <= we;
            err_reg   <= req_err;
            idx_reg   <= word_idx[AW-1:0];
            wdata_reg <= wdata;
            be_reg    <= be;
            ready_reg <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESPOSTA;
            end else begin
              state_reg <= ESPERA;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end
        ESPERA: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESPOSTA;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESPOSTA: begin
          state_reg <= OCIOSO;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= OCIOSO;
          ready_reg <= 1'b1;
        end
      endcase
      if (go_resp) begin
        done_reg <= 1'b1;
        erro_reg <= acc_err;
        // rsel selects the RAM word; a failed read forces rdata to zero until the next good read.
        if (!acc_we) begin
          rsel_reg <= ~acc_err;
        end
      end
    end
  end

  // Storage carries no reset so it maps onto block RAM and survives reset.
  always_ff @(posedge clock) begin
    if (go_resp && !acc_err) begin
      if (acc_we) begin
        for (int b = 0; b < NB; b++) begin
          if (acc_be[b]) begin
            mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end
      end else begin
        ram_q <= mem[acc_idx];
      end
    end
  end

`ifdef MEM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'(i);
    end
  end
`endif

  assign ready = ready_reg;
  assign done  = done_reg;
  assign erro  = erro_reg;
  assign rdata = rsel_reg ? ram_q : '0;

endmodule

// File: tb/tb_memoria_dados.sv
// Self-checking bench for memoria_dados: a transaction-level memory model drives expectations for a
// WAIT_CYCLES=3 instance every cycle, plus a directed back-to-back run on a WAIT_CYCLES=0 instance.
module tb_memoria_dados;
  localparam int DEPTH = 64;
  localparam int W     = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ready, done, erro;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic        ready0, done0, erro0;
  logic [31:0] rdata0;

  memoria_dados #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .done(done), .rdata(rdata), .erro(erro)
  );

  memoria_dados #(.DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .ready(ready0), .done(done0), .rdata(rdata0), .erro(erro0)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: word array plus the single outstanding access.
  logic [31:0] mmem [DEPTH];
  bit          pend = 1'b0;
  int          pend_acc, pend_done, pend_idx;
  bit          pend_we, pend_err;
  logic [31:0] pend_wdata, pend_rdata;
  logic [3:0]  pend_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // Per-cycle compare against the model.
  initial begin
    int          e;
    bit          busy, exp_done;
    logic [31:0] hold;
`ifdef MEM_INIT_EN
    for (int i = 0; i < DEPTH; i++) mmem[i] = i;
`endif
    hold = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_erro", erro, 0);
        check("rst_rdata", rdata, 0);
        hold = '0;
      end else begin
        e        = cyc;
        busy     = pend && e >= pend_acc && e <= pend_done;
        exp_done = pend && e == pend_done;
        check("ready", ready, !busy);
        check("done", done, exp_done);
        check("erro", erro, exp_done && pend_err);
        if (exp_done) begin
          if (pend_we) begin
            if (!pend_err)
              for (int b = 0; b < 4; b++)
                if (pend_be[b]) mmem[pend_idx][8*b +: 8] = pend_wdata[8*b +: 8];
          end else begin
            hold = pend_err ? 32'h0 : pend_rdata;
          end
        end
        check("rdata", rdata, hold);
      end
    end
  end

  task automatic launch(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clock);
    #1;
    pend_acc   = cyc;
    pend_done  = cyc + W;
    pend_we    = w;
    pend_err   = addr_err(a);
    pend_idx   = int'(a >> 2);
    pend_wdata = d;
    pend_be    = b;
    pend_rdata = (w || pend_err) ? 32'h0 : mmem[pend_idx];
    pend       = 1'b1;
    $display("[%0d] %s addr=%h wdata=%h be=%b exp_err=%0b exp_rdata=%h",
             cyc, w ? "WR" : "RD", a, d, b, pend_err, pend_rdata);
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    launch(w, a, d, b);
    // Scramble the inputs (including stray requests) while the access is in flight.
    req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    while (cyc < pend_done + 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      req = 1'b0;
    end
  endtask

  task automatic w0_burst(input bit w);
    @(negedge clock);
    req0 = 1'b1; we0 = w; be0 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        addr0  = 32'((k / 2) * 4);
        wdata0 = 32'h11111111 * 32'(k / 2 + 1);
      end
      check("w0_ready", ready0, (k % 2 == 0));
      check("w0_done", done0, (k % 2 == 1));
      if (k % 2 == 1) begin
        check("w0_erro", erro0, 0);
        if (!w) check("w0_rdata", rdata0, 32'h11111111 * 32'(k / 2 + 1));
      end
      @(posedge clock);
      @(negedge clock);
    end
    req0 = 1'b0;
    check("w0_idle_done", done0, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          r, widx;
    bit          w;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

`ifdef MEM_INIT_EN
    access(1'b0, 32'h10, 32'h0, 4'h0);
    check("lit_init_word4", pend_rdata, 32'h4);
`endif

    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF);

    access(1'b1, 32'h20, 32'h00000008, 4'hF);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    access(1'b0, 32'h20, $urandom, 4'($urandom));
    check("lit_be_merge", pend_rdata, 32'h00BB00DD);
    access(1'b0, 32'h22, 32'h0, 4'hF);
    check("lit_misaligned_err", 32'(pend_err), 1);
    check("lit_err_rdata", pend_rdata, 0);
    access(1'b1, 32'(DEPTH * 4), 32'hDEADBEEF, 4'hF);
    check("lit_range_err", 32'(pend_err), 1);
    access(1'b1, 32'h22, 32'h12345678, 4'hF);
    access(1'b1, 32'h20, 32'h55555555, 4'h0);
    access(1'b0, 32'h20, 32'h0, 4'h0);
    check("lit_unchanged", pend_rdata, 32'h00BB00DD);

    // Write aborted by reset two cycles after acceptance must leave the old word.
    access(1'b1, 32'h30, 32'h13572468, 4'hF);
    launch(1'b1, 32'h30, 32'h0BADF00D, 4'hF);
    req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    pend = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    access(1'b0, 32'h30, 32'h0, 4'h0);
    check("lit_abort_old", pend_rdata, 32'h13572468);

    repeat (200) begin
      idle(int'($urandom_range(0, 2)));
      r    = int'($urandom_range(0, 9));
      w    = 1'($urandom);
      widx = int'($urandom_range(0, DEPTH - 1));
      if (r < 7)       a = 32'(widx * 4);
      else if (r == 7) a = 32'(widx * 4 + int'($urandom_range(1, 3)));
      else if (r == 8) a = 32'((DEPTH + int'($urandom_range(0, 7))) * 4);
      else             a = $urandom;
      access(w, a, $urandom, 4'($urandom));
    end
    idle(2);

    w0_burst(1'b1);
    w0_burst(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
